food_placer: RTL
================

// Module: food_placer
// PURPOSE
//  Consumer of the random cell generator: on a request from game control, takes candidate
//  cells from rnd_num, checks each against the snake-occupancy RAM, and publishes a free
//  cell as the new food position. After MAX_TRIES rejected candidates it falls back to a
//  wrapping linear scan. Sits between random generator, occupancy RAM and game FSM.
// PARAMETERS
//  GRID_CELLS  100  playable cells; valid indices 0..GRID_CELLS-1
//  POS_W       8    width of cell index
//  MAX_TRIES   8    random candidates tried before linear scan (>=1)
// PORTS
//  clk        in   1      system clock; all state on posedge
//  rst_n      in   1      async active-low reset
//  req        in   1      place new food; sampled only in IDLE
//  rnd_num    in   POS_W  candidate cell from random generator, sampled in SAMPLE
//  occ_rd     out  1      occupancy read strobe (combinational from state)
//  occ_addr   out  POS_W  occupancy read address (= cand)
//  occ_data   in   1      1 = cell occupied; valid the cycle after occ_rd
//  busy       out  1      high in every state except IDLE
//  food_pos   out  POS_W  placed food cell; held until next successful placement
//  food_valid out  1      food_pos is a live placement
//  done       out  1      1-cycle pulse: placement succeeded
//  fail       out  1      1-cycle pulse: no free cell exists
// BEHAVIOUR
//  Reset (any time, incl. mid-search): state=IDLE, cand=0, tries=0, scan_cnt=0,
//   food_pos=0, food_valid=0, done=0, fail=0, busy=0, occ_rd=0. No read pending after.
//  States: IDLE, SAMPLE, ISSUE, CHECK, SCAN_ISSUE, SCAN_CHECK.
//  IDLE: req=1 -> SAMPLE; tries<=0; food_valid<=0. req=0 -> stay.
//  SAMPLE: cand<=rnd_num. rnd_num<GRID_CELLS -> ISSUE. Else reject: tries+1; if
//   tries+1==MAX_TRIES -> SCAN_ISSUE with cand<=0, scan_cnt<=0; else stay SAMPLE.
//  ISSUE: occ_rd=1, occ_addr=cand -> CHECK.
//  CHECK: occ_data=0 -> food_pos<=cand, food_valid<=1, done<=1, -> IDLE.
//   occ_data=1 -> tries+1; MAX_TRIES reached -> SCAN_ISSUE with cand<=(cand+1)
//   wrapped at GRID_CELLS, scan_cnt<=0; else -> SAMPLE.
//  SCAN_ISSUE: occ_rd=1, occ_addr=cand -> SCAN_CHECK.
//  SCAN_CHECK: occ_data=0 -> success as in CHECK. Occupied: scan_cnt+1; if
//   scan_cnt+1==GRID_CELLS -> fail<=1, food_valid stays 0, -> IDLE; else
//   cand<=cand+1 (GRID_CELLS-1 wraps to 0) -> SCAN_ISSUE.
//  Latency: req seen at edge 0 -> done high after edge 3 (first candidate free).
//   Each extra random try +3 cycles (+1 if out of range); each scan step +2.
//  Worst case bounded: MAX_TRIES*3 + GRID_CELLS*2 + 1 cycles.
//  req while busy: ignored, not queued. done/fail mutually exclusive, never both.
//  occ_rd only for in-range addresses; occ_data ignored outside CHECK/SCAN_CHECK.
//  Index arithmetic POS_W bits; compare to GRID_CELLS before incrementing (no overflow).
// STRUCTURE
//  Shared package snake_pkg: GRID_CELLS, POS_W, GRID_W=10, placer state enum.
//  Single FSM + cand/tries/scan_cnt counters; no sub-module warranted.
// TESTING
//  1 req, rnd_num=45, occ(45)=0 -> occ_rd once at 45, done after edge 3, food_pos=45.
//  2 rnd_num 45,67,72 occupied, then 33 free -> 4 reads, food_pos=33, done, no fail.
//  3 rnd_num stuck 55 occupied, MAX_TRIES=8, cells 0..9 occupied -> scan from 56,
//    food_pos=56; with 56..99,0..9 occupied and 10 free -> wraps, food_pos=10.
//  4 all 100 cells occupied -> fail pulse once, food_valid=0, back IDLE, no done.
//  5 rnd_num=150 -> no occ_rd issued, counts as try; next rnd_num=20 free -> food_pos=20.
//  6 rst_n low during SCAN_CHECK -> all outputs 0 immediately; req then -> normal placement.

Source files
------------

// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game datapath.
package snake_pkg;

    localparam int unsigned GRID_CELLS   = 100;
    localparam int unsigned POS_W        = 8;
    localparam int unsigned GRID_W       = 10;
    localparam int unsigned PL_MAX_TRIES = 8;

    typedef enum logic [2:0] {
        PL_IDLE,
        PL_SAMPLE,
        PL_ISSUE,
        PL_CHECK,
        PL_SCAN_ISSUE,
        PL_SCAN_CHECK
    } placer_state_e;

endpackage : snake_pkg

// File: rtl/food_placer.sv
// Food placement: random candidates checked against occupancy RAM, then a
// wrapping linear scan once the random tries are exhausted.
module food_placer
    import snake_pkg::*;
#(
    parameter int unsigned MAX_TRIES = PL_MAX_TRIES
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             req,
    input  logic [POS_W-1:0] rnd_num,
    output logic             occ_rd,
    output logic [POS_W-1:0] occ_addr,
    input  logic             occ_data,
    output logic             busy,
    output logic [POS_W-1:0] food_pos,
    output logic             food_valid,
    output logic             done,
    output logic             fail
);

    localparam int unsigned TRY_W = $clog2(MAX_TRIES + 1);

    placer_state_e    state_q, state_d;
    logic [POS_W-1:0] cand_q, cand_d;
    logic [TRY_W-1:0] tries_q, tries_d;
    logic [GRID_W-1:0] scan_cnt_q, scan_cnt_d;
    logic [POS_W-1:0] food_pos_q, food_pos_d;
    logic             food_valid_q, food_valid_d;
    logic             done_q, done_d;
    logic             fail_q, fail_d;

    logic [POS_W-1:0]  cand_wrap_c;
    logic [TRY_W-1:0]  tries_inc_c;
    logic [GRID_W-1:0] scan_inc_c;

    // Candidate is always in range here, so the wrap compare precedes the add.
    assign cand_wrap_c = (cand_q == POS_W'(GRID_CELLS - 1)) ? '0 : cand_q + POS_W'(1);
    assign tries_inc_c = tries_q + TRY_W'(1);
    assign scan_inc_c  = scan_cnt_q + GRID_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= PL_IDLE;
            cand_q       <= '0;
            tries_q      <= '0;
            scan_cnt_q   <= '0;
            food_pos_q   <= '0;
            food_valid_q <= 1'b0;
            done_q       <= 1'b0;
            fail_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            cand_q       <= cand_d;
            tries_q      <= tries_d;
            scan_cnt_q   <= scan_cnt_d;
            food_pos_q   <= food_pos_d;
            food_valid_q <= food_valid_d;
            done_q       <= done_d;
            fail_q       <= fail_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        cand_d       = cand_q;
        tries_d      = tries_q;
        scan_cnt_d   = scan_cnt_q;
        food_pos_d   = food_pos_q;
        food_valid_d = food_valid_q;
        done_d       = 1'b0;
        fail_d       = 1'b0;

        unique case (state_q)
            PL_IDLE: begin
                if (req) begin
                    state_d      = PL_SAMPLE;
                    tries_d      = '0;
                    food_valid_d = 1'b0;
                end
            end
            PL_SAMPLE: begin
                cand_d = rnd_num;
                if (rnd_num < POS_W'(GRID_CELLS)) begin
                    state_d = PL_ISSUE;
                end else begin
                    tries_d = tries_inc_c;
                    if (tries_inc_c == TRY_W'(MAX_TRIES)) begin
                        state_d    = PL_SCAN_ISSUE;
                        cand_d     = '0;
                        scan_cnt_d = '0;
                    end
                end
            end
            PL_ISSUE: state_d = PL_CHECK;
            PL_CHECK: begin
                if (!occ_data) begin
                    state_d      = PL_IDLE;
                    food_pos_d   = cand_q;
                    food_valid_d = 1'b1;
                    done_d       = 1'b1;
                end else begin
                    tries_d = tries_inc_c;
                    if (tries_inc_c == TRY_W'(MAX_TRIES)) begin
                        state_d    = PL_SCAN_ISSUE;
                        cand_d     = cand_wrap_c;
                        scan_cnt_d = '0;
                    end else begin
                        state_d = PL_SAMPLE;
                    end
                end
            end
            PL_SCAN_ISSUE: state_d = PL_SCAN_CHECK;
            PL_SCAN_CHECK: begin
                if (!occ_data) begin
                    state_d      = PL_IDLE;
                    food_pos_d   = cand_q;
                    food_valid_d = 1'b1;
                    done_d       = 1'b1;
                end else begin
                    scan_cnt_d = scan_inc_c;
                    if (scan_inc_c == GRID_W'(GRID_CELLS)) begin
                        state_d = PL_IDLE;
                        fail_d  = 1'b1;
                    end else begin
                        state_d = PL_SCAN_ISSUE;
                        cand_d  = cand_wrap_c;
                    end
                end
            end
            default: state_d = PL_IDLE;
        endcase
    end

    assign occ_rd     = (state_q == PL_ISSUE) || (state_q == PL_SCAN_ISSUE);
    assign occ_addr   = cand_q;
    assign busy       = (state_q != PL_IDLE);
    assign food_pos   = food_pos_q;
    assign food_valid = food_valid_q;
    assign done       = done_q;
    assign fail       = fail_q;

endmodule : food_placer
